// File: rtl/tpu_pkg.sv
// Shared TPU DMA command constants: opcode values and the host request kind enum.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: OP_* opcode localparams, req_op_e, req_opcode() and cmd_word() helpers.
package tpu_pkg;

  localparam logic [3:0] OP_NOP       = 4'b0000;
  localparam logic [3:0] OP_FETCH_W   = 4'b0001;
  localparam logic [3:0] OP_FETCH_INP = 4'b0010;
  localparam logic [3:0] OP_FETCH_INS = 4'b0011;
  localparam logic [3:0] OP_START     = 4'b0100;

  localparam logic [6:0] MAX_LEN = 7'd64;

  typedef enum logic [1:0] {
    REQ_FETCH_W   = 2'd0,
    REQ_FETCH_INP = 2'd1,
    REQ_FETCH_INS = 2'd2,
    REQ_START     = 2'd3
  } req_op_e;

  function automatic logic [3:0] req_opcode(input req_op_e op);
    logic [3:0] opc;
    case (op)
      REQ_FETCH_W:   opc = OP_FETCH_W;
      REQ_FETCH_INP: opc = OP_FETCH_INP;
      REQ_FETCH_INS: opc = OP_FETCH_INS;
      default:       opc = OP_START;
    endcase
    return opc;
  endfunction

  // Command bus layout: opcode in [15:12], [11:6] reserved zero, address in [5:0].
  function automatic logic [15:0] cmd_word(input logic [3:0] opc, input logic [5:0] addr);
    return {opc, 6'b000000, addr};
  endfunction

endpackage

// File: rtl/dma_cmd_gen.sv
// Host-side DMA command word generator: turns one request into a registered sequence of command words.
// Latency: word 0 on uio_out the cycle after acceptance; each word held HOLD_CYCLES cycles; done pulses one cycle after the last word.
// Backpressure: req_ready is high only in IDLE; req_valid at any other time is ignored, nothing is queued.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_op/req_addr/req_len request side;
//        uio_out 16-bit command bus, busy (acceptance..DONE), done (one-cycle completion pulse).
// Build option: DMA_CMD_GEN_IDLE_GAP_EN inserts one NOP cycle between consecutive words.
module dma_cmd_gen
  import tpu_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [5:0]  req_addr,
  input  logic [6:0]  req_len,
  output logic [15:0] uio_out,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);

`ifdef DMA_CMD_GEN_IDLE_GAP_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DONE = 2'd2, ST_GAP = 2'd3} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DONE = 2'd2} state_e;
`endif

  state_e      state_q;
  logic [3:0]  opc_q;
  logic [5:0]  addr_q;
  logic [6:0]  left_q;    // words still to emit after the one currently on the bus
  logic [3:0]  hold_q;
  logic [15:0] uio_q;
  logic        busy_q;
  logic        done_q;

  req_op_e    op_d;
  logic [3:0] opc_d;
  logic [6:0] len_d;
  logic [5:0] addr_d;

  always_comb begin
    op_d   = req_op_e'(req_op);
    opc_d  = req_opcode(op_d);
    // Start always carries exactly one word; fetch lengths above 64 are clamped.
    if (op_d == REQ_START)       len_d = 7'd1;
    else if (req_len > MAX_LEN)  len_d = MAX_LEN;
    else                         len_d = req_len;
    addr_d = addr_q + 6'd1;      // 6-bit wrap 63 -> 0 is intended
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      opc_q   <= OP_NOP;
      addr_q  <= '0;
      left_q  <= '0;
      hold_q  <= '0;
      uio_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q <= ST_ISSUE;
            busy_q  <= 1'b1;
            opc_q   <= opc_d;
            addr_q  <= req_addr;
            if (len_d == 7'd0) begin
              // Zero-length: spend one ISSUE cycle with an idle bus, then DONE.
              left_q <= '0;
              hold_q <= '0;
              uio_q  <= cmd_word(OP_NOP, 6'd0);
            end else begin
              left_q <= 7'(len_d - 7'd1);
              hold_q <= HOLD_LD;
              uio_q  <= cmd_word(opc_d, req_addr);
            end
          end
        end
        ST_ISSUE: begin
          if (hold_q != 4'd0) begin
            hold_q <= hold_q - 4'd1;
          end else if (left_q == 7'd0) begin
            state_q <= ST_DONE;
            uio_q   <= cmd_word(OP_NOP, 6'd0);
            done_q  <= 1'b1;
          end else begin
`ifdef DMA_CMD_GEN_IDLE_GAP_EN
            state_q <= ST_GAP;
            uio_q   <= cmd_word(OP_NOP, 6'd0);
`else
            addr_q  <= addr_d;
            left_q  <= left_q - 7'd1;
            hold_q  <= HOLD_LD;
            uio_q   <= cmd_word(opc_q, addr_d);
`endif
          end
        end
`ifdef DMA_CMD_GEN_IDLE_GAP_EN
        ST_GAP: begin
          state_q <= ST_ISSUE;
          addr_q  <= addr_d;
          left_q  <= left_q - 7'd1;
          hold_q  <= HOLD_LD;
          uio_q   <= cmd_word(opc_q, addr_d);
        end
`endif
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          uio_q   <= '0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign uio_out   = uio_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
